// File: rtl/sisc_fetch_unit_if.sv
// Bus bundle for the SISC fetch front end: instruction-memory port,
// queue-head handshake toward the control unit, and branch redirect.
// master = the fetch unit, slave = the memory/control side.
interface sisc_fetch_unit_if #(
    parameter int AW = 16,
    parameter int IW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          br_taken;
    logic          br_sel;
    logic [15:0]   br_imm;
    logic [AW-1:0] fpc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fpc,
        input  imem_ack, imem_rdata, instr_ready, br_taken, br_sel, br_imm
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fpc,
        output imem_ack, imem_rdata, instr_ready, br_taken, br_sel, br_imm
    );
endinterface

// File: rtl/sisc_fetch_unit.sv
// Decoupled instruction-fetch front end for the SISC core: fetch PC,
// single-outstanding req/ack memory port and a DEPTH-entry {pc, instr}
// prefetch queue with registered head outputs.
// Optional build macro SISC_FETCH_STATS_EN adds saturating statistics
// counters (stat_fetched, stat_flushes, stat_discards).
//
// state | meaning
// IDLE  | no request; waiting for queue space
// REQ   | request at fpc outstanding; ack pushes into the queue
// DRAIN | redirected while a request was pending; next ack is dropped
module sisc_fetch_unit #(
    parameter int AW    = 16,
    parameter int IW    = 32,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_f,
`ifdef SISC_FETCH_STATS_EN
    output logic [31:0] stat_fetched,
    output logic [15:0] stat_flushes,
    output logic [15:0] stat_discards,
`endif
    sisc_fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    fpc_q, fpc_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             req_q;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW+IW-1:0] mem_q [DEPTH];
    logic             valid_q, valid_d;
    logic [IW-1:0]    instr_q, instr_d;
    logic [AW-1:0]    ipc_q, ipc_d;

    logic [AW-1:0]    imm_ext;
    logic [AW-1:0]    target;
    logic             redirect, push, pop, head_bypass;

    if (AW > 16) begin : g_sext
        assign imm_ext = {{(AW-16){bus.br_imm[15]}}, bus.br_imm};
    end else begin : g_trunc
        assign imm_ext = bus.br_imm[AW-1:0];
    end

    // Relative targets are taken from the registered head pc, wrapping mod 2^AW.
    assign target   = bus.br_sel ? imm_ext : ipc_q + AW'(1) + imm_ext;
    assign redirect = bus.br_taken;
    assign pop      = valid_q & bus.instr_ready & ~redirect;
    assign push     = (state_q == REQ) & bus.imem_ack & ~redirect;
    // The new head is the word being pushed when the queue is (or becomes) empty.
    assign head_bypass = push & (count_q == CW'(pop));

    // Next-state for fetch PC, queue pointers, FSM and registered head.
    always_comb begin
        fpc_d   = fpc_q;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (redirect) begin
            fpc_d   = target;
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) begin
                fpc_d = fpc_q + AW'(1);
                wr_d  = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
        end

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!redirect && count_q < CW'(DEPTH)) state_d = REQ;
            REQ: begin
                if (bus.imem_ack) state_d = (count_d < CW'(DEPTH)) ? REQ : IDLE;
                else if (redirect) state_d = DRAIN;
            end
            DRAIN:   if (bus.imem_ack) state_d = REQ;
            default: state_d = IDLE;
        endcase

        // A request in flight never changes address; a fresh one uses the new fpc.
        addr_d = (state_d == REQ) ? fpc_d : addr_q;

        valid_d = (count_d != '0);
        instr_d = instr_q;
        ipc_d   = ipc_q;
        if (valid_d) begin
            if (head_bypass) begin
                ipc_d   = fpc_q;
                instr_d = bus.imem_rdata;
            end else begin
                {ipc_d, instr_d} = mem_q[rd_d];
            end
        end
    end

    // FSM, fetch PC, queue control and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q <= IDLE;
            fpc_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            req_q   <= (state_d != IDLE);
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    // Queue storage; entries are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {fpc_q, bus.imem_rdata};
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.fpc         = fpc_q;

`ifdef SISC_FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [15:0] flushes_q;
    logic [15:0] discards_q;
    logic        discard;

    assign discard = bus.imem_ack & ((state_q == DRAIN) | ((state_q == REQ) & redirect));

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            fetched_q  <= '0;
            flushes_q  <= '0;
            discards_q <= '0;
        end else begin
            if (push && fetched_q != '1)     fetched_q  <= fetched_q + 32'd1;
            if (redirect && flushes_q != '1) flushes_q  <= flushes_q + 16'd1;
            if (discard && discards_q != '1) discards_q <= discards_q + 16'd1;
        end
    end

    assign stat_fetched  = fetched_q;
    assign stat_flushes  = flushes_q;
    assign stat_discards = discards_q;
`endif
endmodule
